// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// state encoding, opcodes, ALU/immediate codes and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Branch condition from the SUB comparison flags; unsupported func3 never branches.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lt);
    logic taken;
    case (f3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R-type and I-type arithmetic instructions.
// func7[5] only selects SUB for R-type; I-type 000 is always ADD (addi).
module alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] alu_control
);

  logic unused_func7_s;
  assign unused_func7_s = ^{func7[6], func7[4:0]};

  // func3 table lookup; unsupported shifts fall back to ADD
  always_comb begin
    alu_control = ALU_ADD;
    case (func3)
      3'b000: begin
        if ((op == OP_RTYPE) && func7[5]) begin
          alu_control = ALU_SUB;
        end else begin
          alu_control = ALU_ADD;
        end
      end
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      3'b100:  alu_control = ALU_XOR;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the shared-memory RISC-V datapath.
// Outputs are decoded from state; write enables are gated off while rst is held.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       Zero,
  input  logic       lt,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc
);

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] alu_dec_s;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_write_s;

  alu_decoder u_alu_decoder (
    .op          (op),
    .func3       (func3),
    .func7       (func7),
    .alu_control (alu_dec_s)
  );

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_next_s = S_FETCH;
    pc_write_s   = 1'b0;
    AdrSrc       = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUControl   = ALU_ADD;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_B;
    ImmSrc       = IMM_I;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jal target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (op == OP_BRANCH) begin
          ImmSrc = IMM_B;
        end else if (op == OP_JAL) begin
          ImmSrc = IMM_J;
        end else begin
          ImmSrc = IMM_I;
        end
        case (op)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_RTYPE:          state_next_s = S_EXECR;
          OP_ITYPE:          state_next_s = S_EXECI;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          OP_JALR:           state_next_s = S_JALR1;
          OP_LUI:            state_next_s = S_LUI;
          default:           state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        if (op == OP_STORE) begin
          ImmSrc       = IMM_S;
          state_next_s = S_MEMWRITE;
        end else begin
          ImmSrc       = IMM_I;
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc       = 1'b1;
        state_next_s = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        mem_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_A;
        ALUControl   = alu_dec_s;
        state_next_s = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_IMM;
        ALUControl   = alu_dec_s;
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = SRCA_A;
        ALUControl   = ALU_SUB;
        pc_write_s   = branch_taken(func3, Zero, lt);
        state_next_s = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC takes the target in ALUOut while the ALU forms the link OldPC+4
        pc_write_s   = 1'b1;
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        state_next_s = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA      = SRCA_A;
        ALUSrcB      = SRCB_IMM;
        state_next_s = S_JALR2;
      end
      S_LUI: begin
        ImmSrc       = IMM_U;
        ALUSrcB      = SRCB_IMM;
        ALUControl   = ALU_PASSB;
        ResultSrc    = RES_ALURESULT;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // Architectural write enables are suppressed whenever rst is held
  always_comb begin
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end else begin
      PCWrite  = pc_write_s;
      IRWrite  = ir_write_s;
      RegWrite = reg_write_s;
      MemWrite = mem_write_s;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: each instruction is expanded into the
// list of per-cycle control vectors it should produce and compared cycle by cycle.
module tb_mc_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       Zero;
  logic       lt;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] q[$];
  logic [16:0] obs;
  assign obs = {PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc,
                ALUControl, ALUSrcA, ALUSrcB, ImmSrc};

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .lt(lt), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Control vector: {PCWrite,AdrSrc,IRWrite,RegWrite,MemWrite,ResultSrc,ALU,SrcA,SrcB,Imm}
  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic irw,
                                     input logic rw, input logic mw, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm);
    return {pcw, adr, irw, rw, mw, rs, alu, sa, sb, imm};
  endfunction

  function automatic logic [2:0] model_alu(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return (is_r && f7[5]) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic z, input logic l);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return l;
    if (f3 == 3'd5) return !l;
    return 1'b0;
  endfunction

  // Expand one instruction into its expected per-cycle control vectors
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic l);
    logic [16:0] fetch, aluwb, jlink;
    fetch = mk(1, 0, 1, 0, 0, 2'd2, 3'd0, 2'd0, 2'd2, 3'd0);
    aluwb = mk(0, 0, 0, 1, 0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0);
    jlink = mk(1, 0, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd2, 3'd0);
    q.delete();
    q.push_back(fetch);
    case (o)
      7'b1100011: q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd1, 3'd2));
      7'b1101111: q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd1, 3'd3));
      default:    q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd1, 2'd1, 3'd0));
    endcase
    case (o)
      7'b0000011: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd1, 3'd0));
        q.push_back(mk(0, 1, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0));
        q.push_back(mk(0, 0, 0, 1, 0, 2'd1, 3'd0, 2'd0, 2'd0, 3'd0));
      end
      7'b0100011: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd1, 3'd1));
        q.push_back(mk(0, 1, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0));
      end
      7'b0110011: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, model_alu(1'b1, f3, f7), 2'd2, 2'd0, 3'd0));
        q.push_back(aluwb);
      end
      7'b0010011: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, model_alu(1'b0, f3, f7), 2'd2, 2'd1, 3'd0));
        q.push_back(aluwb);
      end
      7'b1100011: q.push_back(mk(model_taken(f3, z, l), 0, 0, 0, 0, 2'd0, 3'd1, 2'd2, 2'd0, 3'd0));
      7'b1101111: begin
        q.push_back(jlink);
        q.push_back(aluwb);
      end
      7'b1100111: begin
        q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 2'd2, 2'd1, 3'd0));
        q.push_back(jlink);
        q.push_back(aluwb);
      end
      7'b0110111: q.push_back(mk(0, 0, 0, 1, 0, 2'd2, 3'd7, 2'd0, 2'd1, 3'd4));
      default: ;
    endcase
  endtask

  // Drive one instruction (DUT must be in FETCH) and check every cycle of it
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic l);
    op = o; func3 = f3; func7 = f7; Zero = z; lt = l;
    build(o, f3, f7, z, l);
    for (int i = 0; i < q.size(); i++) begin
      #1;
      n_checks++;
      if (obs !== q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %05h expected %05h", name, i, obs, q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 7'b0100011; func3 = 3'd2; func7 = 7'd0; Zero = 1'b0; lt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_writes cycle %0d: got %b expected 0000", i, {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({IRWrite, PCWrite, ALUSrcB, ResultSrc} !== 6'b111010) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected 111010", {IRWrite, PCWrite, ALUSrcB, ResultSrc});
    end
    @(negedge clk);
    // DUT has moved past FETCH; return to a clean FETCH for the next task
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("add", 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    run_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0);
    run_instr("sltu", 7'b0110011, 3'b011, 7'b0000000, 1'b0, 1'b0);
    run_instr("slli_unsup", 7'b0010011, 3'b001, 7'b0000000, 1'b0, 1'b0);
  endtask

  task automatic test_mem();
    run_instr("lw", 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0);
    run_instr("sw", 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("blt_taken", 7'b1100011, 3'b100, 7'd0, 1'b0, 1'b1);
    run_instr("blt_not", 7'b1100011, 3'b100, 7'd0, 1'b1, 1'b0);
    run_instr("bne_zero", 7'b1100011, 3'b001, 7'd0, 1'b1, 1'b0);
    run_instr("beq_zero", 7'b1100011, 3'b000, 7'd0, 1'b1, 1'b1);
    run_instr("bge_not", 7'b1100011, 3'b101, 7'd0, 1'b0, 1'b1);
    run_instr("b_f3_010", 7'b1100011, 3'b010, 7'd0, 1'b1, 1'b1);
  endtask

  task automatic test_jumps();
    run_instr("jalr", 7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0);
    run_instr("jal", 7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
    run_instr("lui", 7'b0110111, 3'b101, 7'd0, 1'b0, 1'b0);
    run_instr("illegal", 7'b1111111, 3'b000, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    op = 7'b0100011; func3 = 3'd2; func7 = 7'd0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_reach_memwrite: got %b expected 1", MemWrite);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_writes: got %b expected 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== mk(1, 0, 1, 0, 0, 2'd2, 3'd0, 2'd0, 2'd2, 3'd0)) begin
      n_fail++;
      $display("FAIL mid_reset_fetch: got %05h expected fetch vector", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    logic [6:0] o, f7;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      o = (sel < 8) ? ops[sel] : 7'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      run_instr("random", o, 3'($urandom), f7, 1'($urandom), 1'($urandom));
    end
    run_instr("final_nop", 7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch();
    test_jumps();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
